dp_issue_ctrl: RTL and testbench
================================

Name: dp_issue_ctrl

Overview:
- Sequencer for ARMv4 data-processing instructions, sitting on the operand-producer/flag-consumer side of the ALU.
- Accepts one instruction plus Rn/Rm values over a valid/ready handshake.
- Builds operand2 and drives the ALU operand/select inputs, then evaluates the condition field against its NZCV register.
- Issues register writeback and flag update.

Parameters:
- XLEN, 32, datapath width; ALU result is 2*XLEN wide, low XLEN used.
- RADDR_W, 4, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction/operands valid.
- in_ready  out  1  block can accept (IDLE only).
- instr  in  32  ARM instruction word.
- rn_val  in  XLEN  value of Rn.
- rm_val  in  XLEN  value of Rm.
- alu_a  out  XLEN  ALU operand A (Rn).
- alu_b  out  XLEN  ALU operand B (operand2).
- alu_sel  out  4  ALU select = instr[24:21].
- alu_out  in  2*XLEN  ALU result.
- alu_nzcv  in  4  ALU flags {N,Z,C,V}.
- rd_we  out  1  one-cycle writeback strobe.
- rd_addr  out  RADDR_W  instr[15:12].
- rd_data  out  XLEN  alu_out[XLEN-1:0] latched.
- flags  out  4  current NZCV register.
- done  out  1  one-cycle completion pulse.
- skipped  out  1  with done: condition failed.
- undef  out  1  with done: not a supported DP instruction.

Behaviour:
- Reset values: in_ready=0 during reset and 1 on the first IDLE cycle; rd_we=0; done=0; skipped=0; undef=0; flags=4'b0000; alu_a/alu_b/alu_sel/rd_addr/rd_data=0.
- FSM states: IDLE, EXEC, WB. Latency is 2 cycles from accept to done; one instruction per 3 cycles.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture instr, rn_val, rm_val into registers and go to EXEC.
  - in_valid=0 stays in IDLE.
  - Inputs are ignored outside IDLE; in_ready=0.
- EXEC:
  - alu_a = captured Rn; alu_b = operand2; alu_sel = opcode. The ALU is combinational, so its result is valid in the same cycle.
  - Latch alu_out, alu_nzcv, the condition-pass bit and the illegal bit. Go to WB.
- Operand2:
  - I=instr[25]=1: ROR(zero-extended imm8 instr[7:0], 2*instr[11:8]); rotate of 0 means imm8 unchanged.
  - I=0: Rm, shifted per the optional feature.
- Condition instr[31:28]:
  - Standard ARM decode: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL.
  - 4'b1111 is treated as never.
  - Evaluated against the flags register value in EXEC.
- Illegal when any of: instr[27:26]!=2'b00; I=0 && instr[4]=1 (register-specified shift); opcode TST/TEQ/CMP/CMN with S=0.
- WB:
  - done=1.
  - If illegal: undef=1, no writes.
  - Else if condition failed: skipped=1, no writes.
  - Else:
    - rd_we=1 unless opcode in {1000,1001,1010,1011}.
    - If S=instr[20]=1, flags <= latched alu_nzcv in the same cycle.
  - Return to IDLE.
- rd_addr/rd_data hold their values after WB until the next WB. Rd=15 is written like any other register (no PC semantics here).
- Reset asserted mid-EXEC/WB: immediate return to IDLE, no rd_we/done, flags cleared.
- Flags written in WB are visible to the condition of the next instruction, which is accepted no earlier than the following IDLE cycle, so there is no hazard.

Optional Feature:
- DP_SHIFT_EN defined:
  - For I=0, Rm is shifted by immediate amount instr[11:7] with type instr[6:5]: LSL, LSR, ASR, ROR.
  - LSR/ASR with amount 0 means 32: LSR gives 0, ASR gives all sign bits.
  - ROR with amount 0 means RRX using flags C.
- Undefined: operand2 = Rm unchanged; instr[11:5] ignored.
- The register-shift undef rule applies in both builds.

Decomposition:
- Package dp_pkg: opcode localparams (OP_AND..OP_MVN), condition code localparams, FSM state encoding, function cond_pass(cond, nzcv).
- One sub-module, dp_operand2, builds operand2 (rotate immediate and the optional shifter).

Test Plan:
- Reset then ADD R1=R2+imm 0x05, cond AL, S=0, Rn=3 -> alu_sel=0100, alu_b=5, and at WB rd_we=1, rd_addr=1, rd_data=8, flags unchanged.
- Rotate immediate: imm8=0xFF, rot=4 -> alu_b=0xFF000000. MOV S=1 with alu_nzcv=1000 -> flags=1000 at WB.
- CMP S=1 with Rn=Rm=7, alu_nzcv=0100 -> rd_we stays 0, flags=0100. A following EQ MOV writes; a following NE MOV gives done=1, skipped=1, rd_we=0.
- instr=0xE5912000 (LDR) -> done=1, undef=1, no rd_we, flags unchanged. CMP with S=0 -> undef=1.
- Assert rst during EXEC of an ADD -> no rd_we or done, flags=0, in_ready=1 on the first cycle after release. in_valid held high across 3 instructions -> accepted only in IDLE, 3-cycle spacing.
- DP_SHIFT_EN: Rm=0x80000000, ASR #0 -> alu_b=0xFFFFFFFF. Without the macro, the same instr gives alu_b=0x80000000.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared definitions for the ARMv4 data-processing issue sequencer:
// opcodes, condition codes, FSM encoding and condition evaluation.
package dp_pkg;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   // nzcv is packed {N,Z,C,V}; NV never passes.
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: return z;
         COND_NE: return !z;
         COND_CS: return c;
         COND_CC: return !c;
         COND_MI: return n;
         COND_PL: return !n;
         COND_VS: return v;
         COND_VC: return !v;
         COND_HI: return c && !z;
         COND_LS: return !c || z;
         COND_GE: return n == v;
         COND_LT: return n != v;
         COND_GT: return !z && (n == v);
         COND_LE: return z || (n != v);
         COND_AL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dp_operand2.sv
// Operand2 builder: rotated 8-bit immediate, or Rm (shifted by an immediate
// amount only when DP_SHIFT_EN is defined; otherwise Rm passes unchanged).
module dp_operand2
   import dp_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            use_imm,
   input  logic [11:0]     op2_field,
   input  logic [XLEN-1:0] rm,
   input  logic            carry_in,
   output logic [XLEN-1:0] op2
);

   logic [XLEN-1:0]   w_imm_ext;
   logic [4:0]        w_rot;
   logic [2*XLEN-1:0] w_imm_dbl;
   logic [XLEN-1:0]   w_rm_op;

   assign w_imm_ext = {{(XLEN-8){1'b0}}, op2_field[7:0]};
   assign w_rot     = {op2_field[11:8], 1'b0};
   assign w_imm_dbl = {w_imm_ext, w_imm_ext} >> w_rot;

`ifdef DP_SHIFT_EN
   logic [4:0]        w_amt;
   logic [2*XLEN-1:0] w_ror_dbl;

   assign w_amt     = op2_field[11:7];
   assign w_ror_dbl = {rm, rm} >> w_amt;

   // Amount 0 encodes LSR/ASR #32 and RRX.
   always_comb begin
      w_rm_op = rm;
      case (op2_field[6:5])
         2'b00: w_rm_op = rm << w_amt;
         2'b01: w_rm_op = (w_amt == 5'd0) ? '0 : (rm >> w_amt);
         2'b10: w_rm_op = (w_amt == 5'd0) ? {XLEN{rm[XLEN-1]}}
                                          : $unsigned($signed(rm) >>> w_amt);
         default: w_rm_op = (w_amt == 5'd0) ? {carry_in, rm[XLEN-1:1]}
                                            : w_ror_dbl[XLEN-1:0];
      endcase
   end
`else
   logic w_unused_carry;

   assign w_unused_carry = &{1'b0, carry_in};
   assign w_rm_op        = rm;
`endif

   assign op2 = use_imm ? w_imm_dbl[XLEN-1:0] : w_rm_op;

endmodule

// File: rtl/dp_issue_ctrl.sv
// ARMv4 data-processing issue sequencer: IDLE -> EXEC -> WB, drives the external
// combinational ALU and performs condition check, writeback and NZCV update.
module dp_issue_ctrl
   import dp_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        instr,
   input  logic [XLEN-1:0]    rn_val,
   input  logic [XLEN-1:0]    rm_val,
   output logic [XLEN-1:0]    alu_a,
   output logic [XLEN-1:0]    alu_b,
   output logic [3:0]         alu_sel,
   input  logic [2*XLEN-1:0]  alu_out,
   input  logic [3:0]         alu_nzcv,
   output logic               rd_we,
   output logic [RADDR_W-1:0] rd_addr,
   output logic [XLEN-1:0]    rd_data,
   output logic [3:0]         flags,
   output logic               done,
   output logic               skipped,
   output logic               undef
);

   state_t             r_state;
   logic [31:0]        r_instr;
   logic [XLEN-1:0]    r_alu_a;
   logic [XLEN-1:0]    r_alu_b;
   logic [3:0]         r_alu_sel;
   logic               r_rd_we;
   logic [RADDR_W-1:0] r_rd_addr;
   logic [XLEN-1:0]    r_rd_data;
   logic [3:0]         r_flags;
   logic               r_done;
   logic               r_skipped;
   logic               r_undef;

   logic [XLEN-1:0]    w_op2;
   logic               w_illegal;
   logic               w_pass;
   logic               w_writes_rd;
   logic               w_unused_bits;

   // Operand2 is formed from the incoming word at accept so the ALU inputs are
   // already stable for the whole EXEC cycle.
   dp_operand2 #(.XLEN(XLEN)) u_operand2 (
      .use_imm   (instr[25]),
      .op2_field (instr[11:0]),
      .rm        (rm_val),
      .carry_in  (r_flags[1]),
      .op2       (w_op2)
   );

   assign w_illegal = (r_instr[27:26] != 2'b00)
                    || (!r_instr[25] && r_instr[4])
                    || ((r_instr[24:23] == 2'b10) && !r_instr[20]);
   assign w_pass      = cond_pass(r_instr[31:28], r_flags);
   assign w_writes_rd = (r_instr[24:23] != 2'b10);
   assign w_unused_bits = &{1'b0, r_instr[19:16], r_instr[11:5], r_instr[3:0],
                            alu_out[2*XLEN-1:XLEN]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_instr   <= '0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_sel <= '0;
         r_rd_we   <= 1'b0;
         r_rd_addr <= '0;
         r_rd_data <= '0;
         r_flags   <= 4'b0000;
         r_done    <= 1'b0;
         r_skipped <= 1'b0;
         r_undef   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_instr   <= instr;
                  r_alu_a   <= rn_val;
                  r_alu_b   <= w_op2;
                  r_alu_sel <= instr[24:21];
                  r_state   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_done    <= 1'b1;
               r_undef   <= w_illegal;
               r_skipped <= !w_illegal && !w_pass;
               if (!w_illegal && w_pass) begin
                  if (w_writes_rd) begin
                     r_rd_we   <= 1'b1;
                     r_rd_addr <= r_instr[15:12];
                     r_rd_data <= alu_out[XLEN-1:0];
                  end
                  if (r_instr[20]) begin
                     r_flags <= alu_nzcv;
                  end
               end
               r_state <= ST_WB;
            end
            ST_WB: begin
               r_done    <= 1'b0;
               r_rd_we   <= 1'b0;
               r_skipped <= 1'b0;
               r_undef   <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready = (r_state == ST_IDLE) && !rst;
   assign alu_a    = r_alu_a;
   assign alu_b    = r_alu_b;
   assign alu_sel  = r_alu_sel;
   assign rd_we    = r_rd_we;
   assign rd_addr  = r_rd_addr;
   assign rd_data  = r_rd_data;
   assign flags    = r_flags;
   assign done     = r_done;
   assign skipped  = r_skipped;
   assign undef    = r_undef;

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Directed, table-driven bench for dp_issue_ctrl, plus reset-in-EXEC and
// back-to-back in_valid sequences.
module tb_dp_issue_ctrl;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [31:0]     rn_val;
   logic [31:0]     rm_val;
   logic [31:0]     alu_a;
   logic [31:0]     alu_b;
   logic [3:0]      alu_sel;
   logic [63:0]     alu_out;
   logic [3:0]      alu_nzcv;
   logic            rd_we;
   logic [3:0]      rd_addr;
   logic [31:0]     rd_data;
   logic [3:0]      flags;
   logic            done;
   logic            skipped;
   logic            undef;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dp_issue_ctrl #(.XLEN(XLEN), .RADDR_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .instr    (instr),
      .rn_val   (rn_val),
      .rm_val   (rm_val),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_sel  (alu_sel),
      .alu_out  (alu_out),
      .alu_nzcv (alu_nzcv),
      .rd_we    (rd_we),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .flags    (flags),
      .done     (done),
      .skipped  (skipped),
      .undef    (undef)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rn;
      logic [31:0] rm;
      logic [31:0] res;
      logic [3:0]  nzcv;
      logic [31:0] e_a;
      logic [31:0] e_b;
      logic [3:0]  e_sel;
      logic        e_we;
      logic [3:0]  e_addr;
      logic [31:0] e_data;
      logic [3:0]  e_flags;
      logic        e_skip;
      logic        e_undef;
   } vec_t;

   localparam int NV = 14;
   vec_t vt [NV];

   function automatic logic [31:0] mk(input logic [3:0] c, input logic i, input logic [3:0] op,
                                      input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                      input logic [11:0] o2);
      return {c, 2'b00, i, op, s, rn, rd, o2};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
   task automatic run_vec(input int idx, input vec_t v);
      instr    = v.instr;
      rn_val   = v.rn;
      rm_val   = v.rm;
      alu_out  = {32'hDEAD_BEEF, v.res};
      alu_nzcv = v.nzcv;
      in_valid = 1'b1;
      #1;
      chk("in_ready_idle", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("alu_a", alu_a, v.e_a);
      chk("alu_b", alu_b, v.e_b);
      chk("alu_sel", alu_sel, v.e_sel);
      chk("in_ready_exec", in_ready, 1'b0);
      chk("done_exec", done, 1'b0);
      @(negedge clk);
      #1;
      chk("done_wb", done, 1'b1);
      chk("rd_we_wb", rd_we, v.e_we);
      chk("skipped_wb", skipped, v.e_skip);
      chk("undef_wb", undef, v.e_undef);
      chk("flags_wb", flags, v.e_flags);
      if (v.e_we) begin
         chk("rd_addr_wb", rd_addr, v.e_addr);
         chk("rd_data_wb", rd_data, v.e_data);
      end
      $display("vec %0d instr=%08h a=%08h b=%08h sel=%h we=%0b rd=%0d data=%08h flags=%04b skip=%0b undef=%0b",
               idx, v.instr, alu_a, alu_b, alu_sel, rd_we, rd_addr, rd_data, flags, skipped, undef);
      @(negedge clk);
      #1;
      chk("done_clear", done, 1'b0);
      chk("rd_we_clear", rd_we, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] add_i;
      logic [8:0]  exp_rdy;
      logic [8:0]  exp_done;

      //            instr                             rn           rm           res          nzcv     e_a          e_b          sel   we    addr   data         flags    skip  undef
      vt[0]  = '{mk(4'hE,1'b1,4'h4,1'b0,4'h2,4'h1,12'h005), 32'd3, 32'd0, 32'd8, 4'b0000, 32'd3, 32'd5, 4'h4, 1'b1, 4'd1, 32'd8, 4'b0000, 1'b0, 1'b0};
      vt[1]  = '{mk(4'hE,1'b1,4'hD,1'b1,4'h0,4'h4,12'h4FF), 32'd0, 32'd0, 32'hFF000000, 4'b1000, 32'd0, 32'hFF000000, 4'hD, 1'b1, 4'd4, 32'hFF000000, 4'b1000, 1'b0, 1'b0};
      vt[2]  = '{mk(4'hE,1'b0,4'hA,1'b1,4'h7,4'h0,12'h007), 32'd7, 32'd7, 32'd0, 4'b0100, 32'd7, 32'd7, 4'hA, 1'b0, 4'd0, 32'd0, 4'b0100, 1'b0, 1'b0};
      vt[3]  = '{mk(4'h0,1'b1,4'hD,1'b0,4'h0,4'h2,12'h011), 32'd0, 32'd0, 32'h11, 4'b0000, 32'd0, 32'h11, 4'hD, 1'b1, 4'd2, 32'h11, 4'b0100, 1'b0, 1'b0};
      vt[4]  = '{mk(4'h1,1'b1,4'hD,1'b1,4'h0,4'h3,12'h001), 32'd0, 32'd0, 32'd1, 4'b0001, 32'd0, 32'd1, 4'hD, 1'b0, 4'd0, 32'd0, 4'b0100, 1'b1, 1'b0};
      vt[5]  = '{32'hE5912000, 32'h55, 32'h123, 32'h999, 4'b1111, 32'h55, 32'h123, 4'hC, 1'b0, 4'd0, 32'd0, 4'b0100, 1'b0, 1'b1};
      vt[6]  = '{mk(4'hE,1'b0,4'hA,1'b0,4'h1,4'h0,12'h002), 32'd1, 32'd9, 32'd0, 4'b0011, 32'd1, 32'd9, 4'hA, 1'b0, 4'd0, 32'd0, 4'b0100, 1'b0, 1'b1};
      vt[7]  = '{mk(4'hE,1'b0,4'h4,1'b1,4'h1,4'h5,12'h012), 32'd4, 32'd2, 32'd6, 4'b1111, 32'd4, 32'd2, 4'h4, 1'b0, 4'd0, 32'd0, 4'b0100, 1'b0, 1'b1};
      vt[8]  = '{mk(4'hC,1'b1,4'h4,1'b0,4'h0,4'h3,12'h001), 32'd0, 32'd0, 32'd1, 4'b0000, 32'd0, 32'd1, 4'h4, 1'b0, 4'd0, 32'd0, 4'b0100, 1'b1, 1'b0};
      vt[9]  = '{mk(4'hD,1'b1,4'h2,1'b1,4'h1,4'h6,12'h001), 32'd1, 32'd0, 32'd0, 4'b0110, 32'd1, 32'd1, 4'h2, 1'b1, 4'd6, 32'd0, 4'b0110, 1'b0, 1'b0};
      vt[10] = '{mk(4'h8,1'b1,4'hD,1'b0,4'h0,4'h7,12'h001), 32'd0, 32'd0, 32'd1, 4'b0000, 32'd0, 32'd1, 4'hD, 1'b0, 4'd0, 32'd0, 4'b0110, 1'b1, 1'b0};
      vt[11] = '{mk(4'h2,1'b1,4'hD,1'b0,4'h0,4'hF,12'h0AB), 32'd0, 32'd0, 32'hAB, 4'b0000, 32'd0, 32'hAB, 4'hD, 1'b1, 4'd15, 32'hAB, 4'b0110, 1'b0, 1'b0};
      vt[12] = '{mk(4'hE,1'b1,4'h0,1'b1,4'h2,4'hA,12'h0F0), 32'h1F, 32'd0, 32'h10, 4'b1010, 32'h1F, 32'hF0, 4'h0, 1'b1, 4'd10, 32'h10, 4'b1010, 1'b0, 1'b0};
`ifdef DP_SHIFT_EN
      vt[13] = '{mk(4'hE,1'b0,4'hD,1'b0,4'h0,4'h9,12'h043), 32'd0, 32'h80000000, 32'h1234, 4'b0000, 32'd0, 32'hFFFFFFFF, 4'hD, 1'b1, 4'd9, 32'h1234, 4'b1010, 1'b0, 1'b0};
`else
      vt[13] = '{mk(4'hE,1'b0,4'hD,1'b0,4'h0,4'h9,12'h043), 32'd0, 32'h80000000, 32'h1234, 4'b0000, 32'd0, 32'h80000000, 4'hD, 1'b1, 4'd9, 32'h1234, 4'b1010, 1'b0, 1'b0};
`endif

      rst      = 1'b1;
      in_valid = 1'b0;
      instr    = '0;
      rn_val   = '0;
      rm_val   = '0;
      alu_out  = '0;
      alu_nzcv = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rd_we", rd_we, 1'b0);
      chk("rst_flags", flags, 4'b0000);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("first_idle_ready", in_ready, 1'b1);
      @(negedge clk);

      for (int k = 0; k < NV; k++) begin
         run_vec(k, vt[k]);
      end

      // Reset while an ADD is in EXEC: no writeback, flags cleared.
      add_i    = mk(4'hE, 1'b1, 4'h4, 1'b0, 4'h2, 4'h1, 12'h005);
      instr    = add_i;
      rn_val   = 32'd3;
      alu_out  = 64'd8;
      alu_nzcv = 4'b1111;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("rstx_done", done, 1'b0);
      chk("rstx_rd_we", rd_we, 1'b0);
      chk("rstx_flags", flags, 4'b0000);
      chk("rstx_in_ready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstx_release_ready", in_ready, 1'b1);
      chk("rstx_release_done", done, 1'b0);
      $display("reset during EXEC: done=%0b rd_we=%0b flags=%04b in_ready=%0b", done, rd_we, flags, in_ready);

      // in_valid held high: accepted only in IDLE, one instruction every 3 cycles.
      exp_rdy  = 9'b001001001;
      exp_done = 9'b100100100;
      in_valid = 1'b1;
      for (int c = 0; c < 9; c++) begin
         chk($sformatf("stream_ready_c%0d", c), in_ready, exp_rdy[c]);
         chk($sformatf("stream_done_c%0d", c), done, exp_done[c]);
         if (exp_done[c]) chk($sformatf("stream_rd_data_c%0d", c), rd_data, 32'd8);
         $display("stream cycle %0d: in_ready=%0b done=%0b rd_we=%0b", c, in_ready, done, rd_we);
         @(negedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
